// File: rtl/andor_pipe.sv
// Two-stage valid/ready pipeline evaluating a TERMS x WIDTH two-level function (AND-OR, OR-AND, AOI, XOR-OR).
// Optional delivery statistics are enabled by defining ANDOR_PIPE_STATS_EN.
module andor_pipe #(
  parameter int WIDTH = 4,
  parameter int TERMS = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TERMS*WIDTH-1:0] in_a,
  input  logic [TERMS*WIDTH-1:0] in_b,
  input  logic [1:0]             in_mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WIDTH-1:0]       out_y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            stat_total,
  output logic [15:0]            stat_hits
);

  localparam int TW = TERMS * WIDTH;

  function automatic logic [TW-1:0] form_terms(input logic [TW-1:0] a,
                                               input logic [TW-1:0] b,
                                               input logic [1:0]    mode);
    logic [TW-1:0] t;
    case (mode)
      2'd1:    t = a | b;
      2'd3:    t = a ^ b;
      default: t = a & b;
    endcase
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] reduce_terms(input logic [TW-1:0] t,
                                                    input logic [1:0]    mode);
    logic [WIDTH-1:0] any_v;
    logic [WIDTH-1:0] all_v;
    logic [WIDTH-1:0] r;
    any_v = '0;
    all_v = '1;
    for (int k = 0; k < TERMS; k++) begin
      any_v = any_v | t[k*WIDTH +: WIDTH];
      all_v = all_v & t[k*WIDTH +: WIDTH];
    end
    case (mode)
      2'd1:    r = all_v;
      2'd2:    r = ~any_v;
      default: r = any_v;
    endcase
    return r;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [TW-1:0]    s1_terms_q, s1_terms_d;
  logic [1:0]       s1_mode_q,  s1_mode_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q,     out_y_d;
  logic             s2_load;
  logic             in_fire;

  // Handshake: stage 2 can take new data when empty or draining this cycle
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_load;
    in_fire  = in_valid && in_ready;
  end

  // Stage 1 next state: load on input transfer, empty when its content moves on
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_terms_d = s1_terms_q;
    s1_mode_d  = s1_mode_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_terms_d = form_terms(in_a, in_b, in_mode);
      s1_mode_d  = in_mode;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // Stage 2 next state: take stage 1 whenever stage 2 is free or leaving
  always_comb begin
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_y_d = reduce_terms(s1_terms_q, s1_mode_q);
      end else begin
        out_y_d = out_y_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Pipeline registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_terms_q  <= '0;
      s1_mode_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_terms_q  <= s1_terms_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;

`ifdef ANDOR_PIPE_STATS_EN
  logic        out_fire;
  logic [15:0] stat_total_q, stat_total_d;
  logic [15:0] stat_hits_q,  stat_hits_d;

  // Saturating delivery counters
  always_comb begin
    out_fire     = out_valid_q && out_ready;
    stat_total_d = stat_total_q;
    stat_hits_d  = stat_hits_q;
    if (out_fire && (stat_total_q != 16'hFFFF)) begin
      stat_total_d = stat_total_q + 16'd1;
    end else begin
      stat_total_d = stat_total_q;
    end
    if (out_fire && (out_y_q != '0) && (stat_hits_q != 16'hFFFF)) begin
      stat_hits_d = stat_hits_q + 16'd1;
    end else begin
      stat_hits_d = stat_hits_q;
    end
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_total_q <= 16'd0;
      stat_hits_q  <= 16'd0;
    end else begin
      stat_total_q <= stat_total_d;
      stat_hits_q  <= stat_hits_d;
    end
  end

  assign stat_total = stat_total_q;
  assign stat_hits  = stat_hits_q;
`else
  assign stat_total = 16'h0000;
  assign stat_hits  = 16'h0000;
`endif

endmodule
